// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the Wishbone master bridge.
//   - default widths and timeout used as parameter defaults
//   - FSM state encoding
//   - stall-vector zero constant
//   - CNT_W: width of the optional BUSY timeout counter
package wb_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_STALL_W = 6;
   localparam int DEF_TIMEOUT = 255;
   localparam int CNT_W       = 16;

   localparam logic [DEF_STALL_W-1:0] STALL_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE           = 2'b00,
      BUSY           = 2'b01,
      WAIT_FOR_STALL = 2'b11
   } wb_state_t;

endpackage

// File: rtl/wb_if.sv
// wb_if: Wishbone bus signals between the CPU-side master bridge and a slave.
//   master modport: drives addr/data/we/sel/stb/cyc; receives data/ack/err
//   slave  modport: the mirror image
// Signal names keep the master's point of view (_i = into master).
interface wb_if
   import wb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) ();

   logic [DATA_W-1:0]   wishbone_data_i;
   logic                wishbone_ack_i;
   logic                wishbone_err_i;
   logic [ADDR_W-1:0]   wishbone_addr_o;
   logic [DATA_W-1:0]   wishbone_data_o;
   logic                wishbone_we_o;
   logic [DATA_W/8-1:0] wishbone_sel_o;
   logic                wishbone_stb_o;
   logic                wishbone_cyc_o;

   modport master (
      input  wishbone_data_i, wishbone_ack_i, wishbone_err_i,
      output wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o,
             wishbone_stb_o, wishbone_cyc_o
   );

   modport slave (
      output wishbone_data_i, wishbone_ack_i, wishbone_err_i,
      input  wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o,
             wishbone_stb_o, wishbone_cyc_o
   );

endinterface

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: counts BUSY cycles of one bus transfer.
//   clk, rst : clock, async active-high reset
//   start    : pulse on the edge that enters BUSY (clears the count)
//   busy     : FSM is in BUSY this cycle (count advances)
//   expired  : this BUSY cycle is the TIMEOUT-th one
// Only instantiated when WB_TIMEOUT_EN is defined.
module wb_timeout_cnt
   import wb_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic busy,
   output logic expired
);

   // Count is 0 in the first BUSY cycle, so the TIMEOUT-th cycle sees TIMEOUT-1.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        cnt_q <= '0;
      else if (start) cnt_q <= '0;
      else if (busy)  cnt_q <= cnt_q + CNT_W'(1);
   end

   assign expired = busy && (cnt_q == LAST);

endmodule

// File: rtl/wb_master_if.sv
// wb_master_if: bridges a stallable CPU pipeline access onto a Wishbone bus.
//   clk, rst         : clock, async active-high reset
//   stall_i, flush_i : pipeline stall vector / exception flush
//   cpu_*_i          : access request (ce, addr, data, we, sel)
//   cpu_data_o/err_o : read data / bus-error-or-timeout result
//   stallreq         : holds the pipeline while the access is pending
//   wb               : Wishbone master port (wb_if.master)
// Optional feature: define WB_TIMEOUT_EN to abort a BUSY transfer after
// TIMEOUT cycles without ack/err (reported as an error).
//
// state          | meaning
// IDLE           | no transfer; a CPU request launches one on the next edge
// BUSY           | stb/cyc asserted, waiting for ack, err, flush or timeout
// WAIT_FOR_STALL | transfer done, pipeline still stalled; result replayed
module wb_master_if
   import wb_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int STALL_W = DEF_STALL_W,
   parameter int TIMEOUT = DEF_TIMEOUT,
   localparam int SEL_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [STALL_W-1:0] stall_i,
   input  logic              flush_i,
   input  logic              cpu_ce_i,
   input  logic [DATA_W-1:0] cpu_data_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic              cpu_we_i,
   input  logic [SEL_W-1:0]  cpu_sel_i,
   output logic [DATA_W-1:0] cpu_data_o,
   output logic              cpu_err_o,
   output logic              stallreq,
   wb_if.master              wb
);

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("wb_master_if: TIMEOUT must be in 1..65535");
   end
   if (DATA_W % 8 != 0) begin : g_bad_width
      $error("wb_master_if: DATA_W must be a multiple of 8");
   end

   wb_state_t         state_q, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              we_q;
   logic [SEL_W-1:0]  sel_q;
   logic              stb_q;
   logic [DATA_W-1:0] rd_buf_q;
   logic              err_buf_q;

   logic              stall_active;
   logic              timeout_hit;
   logic              launch, bus_end, buf_load;
   logic              stall_c, err_c;
   logic [DATA_W-1:0] data_c;

   assign stall_active = (stall_i != STALL_W'(STALL_ZERO));

`ifdef WB_TIMEOUT_EN
   wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .start   (launch),
      .busy    (state_q == BUSY),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // Priority in BUSY: err/timeout > ack > flush. A flush only aborts when the
   // slave has not already terminated the cycle, so completed data is never lost.
   always_comb begin
      state_nxt = state_q;
      stall_c   = 1'b0;
      err_c     = 1'b0;
      data_c    = '0;
      launch    = 1'b0;
      bus_end   = 1'b0;
      buf_load  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_ce_i && !flush_i) begin
               stall_c   = 1'b1;
               launch    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (wb.wishbone_err_i || timeout_hit) begin
               err_c     = 1'b1;
               bus_end   = 1'b1;
               buf_load  = 1'b1;
               state_nxt = stall_active ? WAIT_FOR_STALL : IDLE;
            end else if (wb.wishbone_ack_i) begin
               data_c    = we_q ? '0 : wb.wishbone_data_i;
               bus_end   = 1'b1;
               buf_load  = 1'b1;
               state_nxt = stall_active ? WAIT_FOR_STALL : IDLE;
            end else if (flush_i) begin
               bus_end   = 1'b1;
               state_nxt = IDLE;
            end else begin
               stall_c = 1'b1;
            end
         end
         WAIT_FOR_STALL: begin
            data_c = rd_buf_q;
            err_c  = err_buf_q;
            if (!stall_active) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         stb_q     <= 1'b0;
         rd_buf_q  <= '0;
         err_buf_q <= 1'b0;
      end else begin
         state_q <= state_nxt;
         if (launch) begin
            addr_q    <= cpu_addr_i;
            data_q    <= cpu_data_i;
            we_q      <= cpu_we_i;
            sel_q     <= cpu_sel_i;
            stb_q     <= 1'b1;
            rd_buf_q  <= '0;
            err_buf_q <= 1'b0;
         end else if (bus_end) begin
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            stb_q     <= 1'b0;
            // Completion keeps the delivered result; a flush abort discards it.
            rd_buf_q  <= buf_load ? data_c : '0;
            err_buf_q <= buf_load ? err_c : 1'b0;
         end
      end
   end

   // Reset must silence the combinational CPU outputs immediately, even while
   // a request or ack is still being presented.
   assign stallreq   = stall_c & ~rst;
   assign cpu_err_o  = err_c & ~rst;
   assign cpu_data_o = rst ? '0 : data_c;

   assign wb.wishbone_addr_o = addr_q;
   assign wb.wishbone_data_o = data_q;
   assign wb.wishbone_we_o   = we_q;
   assign wb.wishbone_sel_o  = sel_q;
   assign wb.wishbone_stb_o  = stb_q;
   assign wb.wishbone_cyc_o  = stb_q;

endmodule

// File: tb/tb_wb_master_if.sv
module tb_wb_master_if;
   import wb_pkg::*;

   localparam int TB_TIMEOUT = 4;

   typedef enum int {K_ACK, K_ERR, K_FLUSH, K_FLUSH_ACK, K_TIMEOUT} kind_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic        cpu_ce_i;
   logic [31:0] cpu_data_i;
   logic [31:0] cpu_addr_i;
   logic        cpu_we_i;
   logic [3:0]  cpu_sel_i;
   logic [31:0] cpu_data_o;
   logic        cpu_err_o;
   logic        stallreq;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];

   wb_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   wb_master_if #(
      .DATA_W(32), .ADDR_W(32), .STALL_W(6), .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall_i    (stall_i),
      .flush_i    (flush_i),
      .cpu_ce_i   (cpu_ce_i),
      .cpu_data_i (cpu_data_i),
      .cpu_addr_i (cpu_addr_i),
      .cpu_we_i   (cpu_we_i),
      .cpu_sel_i  (cpu_sel_i),
      .cpu_data_o (cpu_data_o),
      .cpu_err_o  (cpu_err_o),
      .stallreq   (stallreq),
      .wb         (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a cycle where the bus is active but the pipeline is released is
   // a termination; its result and bus fields are compared with the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         chk("stb_eq_cyc", 32'(bus.wishbone_stb_o), 32'(bus.wishbone_cyc_o));
         if (bus.wishbone_cyc_o && !stallreq) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_term", 32'(exp_q.size()), 32'd1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("term_data", cpu_data_o, e.data);
               chk("term_err",  32'(cpu_err_o), 32'(e.err));
               chk("bus_addr",  bus.wishbone_addr_o, e.addr);
               chk("bus_wdata", bus.wishbone_data_o, e.wdata);
               chk("bus_we",    32'(bus.wishbone_we_o), 32'(e.we));
               chk("bus_sel",   32'(bus.wishbone_sel_o), 32'(e.sel));
            end
         end
      end
   end

   // delay: BUSY cycles without termination; hold: cycles stall_i stays
   // non-zero starting with the termination cycle (0 = pipeline not stalled).
   task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic [3:0] sel,
                          input logic [31:0] rdata, input int delay,
                          input kind_t kind, input int hold);
      exp_t e;
      logic waits;
      e.addr  = addr;
      e.wdata = wdata;
      e.we    = we;
      e.sel   = sel;
      e.data  = ((kind == K_ACK || kind == K_FLUSH_ACK) && !we) ? rdata : 32'h0;
      e.err   = (kind == K_ERR || kind == K_TIMEOUT);
      waits   = (kind != K_FLUSH) && (hold > 0);
      exp_q.push_back(e);

      cpu_ce_i   = 1'b1;
      cpu_addr_i = addr;
      cpu_data_i = wdata;
      cpu_we_i   = we;
      cpu_sel_i  = sel;
      flush_i    = 1'b0;
      stall_i    = 6'd0;
      bus.wishbone_ack_i  = 1'b0;
      bus.wishbone_err_i  = 1'b0;
      bus.wishbone_data_i = $urandom;
      @(negedge clk);
      chk("idle_stallreq", 32'(stallreq), 32'd1);
      step();

      // Scramble CPU inputs: the bus fields must stay latched.
      cpu_ce_i   = 1'b0;
      cpu_addr_i = $urandom;
      cpu_data_i = $urandom;
      cpu_we_i   = ~we;
      cpu_sel_i  = 4'($urandom);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk("busy_stallreq", 32'(stallreq), 32'd1);
         chk("busy_err", 32'(cpu_err_o), 32'd0);
         chk("busy_data", cpu_data_o, 32'd0);
         chk("busy_cyc", 32'(bus.wishbone_cyc_o), 32'd1);
         step();
      end

      case (kind)
         K_ACK:       bus.wishbone_ack_i = 1'b1;
         K_ERR:       begin bus.wishbone_err_i = 1'b1; bus.wishbone_ack_i = 1'($urandom_range(0, 1)); end
         K_FLUSH:     flush_i = 1'b1;
         K_FLUSH_ACK: begin flush_i = 1'b1; bus.wishbone_ack_i = 1'b1; end
         K_TIMEOUT:   flush_i = 1'($urandom_range(0, 1));
         default:     ;
      endcase
      stall_i = (hold > 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      bus.wishbone_data_i = rdata;
      @(negedge clk);
      chk("term_stallreq", 32'(stallreq), 32'd0);
      step();

      bus.wishbone_ack_i = 1'b0;
      bus.wishbone_err_i = 1'b0;
      flush_i = 1'b0;
      if (waits) begin
         for (int c = 0; c < hold; c++) begin
            stall_i    = (c == hold - 1) ? 6'd0 : 6'($urandom_range(1, 63));
            cpu_ce_i   = 1'($urandom_range(0, 1));
            cpu_addr_i = $urandom;
            @(negedge clk);
            chk("wait_stallreq", 32'(stallreq), 32'd0);
            chk("wait_data", cpu_data_o, e.data);
            chk("wait_err", 32'(cpu_err_o), 32'(e.err));
            chk("wait_cyc", 32'(bus.wishbone_cyc_o), 32'd0);
            step();
         end
         stall_i = 6'd0;
      end
      cpu_ce_i = 1'b0;
      @(negedge clk);
      chk("post_cyc", 32'(bus.wishbone_cyc_o), 32'd0);
      chk("post_stallreq", 32'(stallreq), 32'd0);
      chk("post_data", cpu_data_o, 32'd0);
      chk("post_err", 32'(cpu_err_o), 32'd0);
      chk("post_addr", bus.wishbone_addr_o, 32'd0);
      step();
      stall_i = 6'd0;
   endtask

   initial begin
      int max_d;
      kind_t k;
      rst = 1'b1;
      stall_i = 6'd0; flush_i = 1'b0;
      cpu_ce_i = 1'b1; cpu_data_i = 32'h1234_5678; cpu_addr_i = 32'h40;
      cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
      bus.wishbone_ack_i = 1'b0; bus.wishbone_err_i = 1'b0;
      bus.wishbone_data_i = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stallreq", 32'(stallreq), 32'd0);
      chk("rst_data", cpu_data_o, 32'd0);
      chk("rst_err", 32'(cpu_err_o), 32'd0);
      chk("rst_cyc", 32'(bus.wishbone_cyc_o), 32'd0);
      chk("rst_addr", bus.wishbone_addr_o, 32'd0);
      step();
      rst = 1'b0;
      cpu_ce_i = 1'b0;
      step();

      // Read with three wait cycles: stallreq high for 4 cycles, data in ack cycle.
      do_xfer(32'h0000_0100, 32'h0, 1'b0, 4'hF, 32'hDEAD_BEEF, 3, K_ACK, 0);
      // Write, ack in 2nd BUSY cycle, pipeline stalled for 3 cycles.
      do_xfer(32'h0000_0200, 32'hCAFE_F00D, 1'b1, 4'b0011, 32'h5555_AAAA, 1, K_ACK, 3);
      // Read that completes while stalled: data replayed during the stall.
      do_xfer(32'h0000_0300, 32'h0, 1'b0, 4'hF, 32'h0BAD_F00D, 0, K_ACK, 2);
      // Slave error in the first BUSY cycle.
      do_xfer(32'h0000_0400, 32'h0, 1'b0, 4'hF, 32'h1111_2222, 0, K_ERR, 0);
      // Flush in the 2nd BUSY cycle aborts without error.
      do_xfer(32'h0000_0500, 32'h0, 1'b0, 4'hF, 32'h3333_4444, 1, K_FLUSH, 2);
      // Flush together with ack: read data still delivered.
      do_xfer(32'h0000_0600, 32'h0, 1'b0, 4'hF, 32'h7777_8888, 1, K_FLUSH_ACK, 0);
`ifdef WB_TIMEOUT_EN
      do_xfer(32'h0000_0700, 32'h0, 1'b0, 4'hF, 32'h9999_AAAA, TB_TIMEOUT - 1, K_TIMEOUT, 0);
      do_xfer(32'h0000_0780, 32'h0, 1'b1, 4'h1, 32'h9999_AAAA, TB_TIMEOUT - 1, K_TIMEOUT, 2);
      max_d = TB_TIMEOUT - 2;
`else
      // Without the timeout, BUSY waits as long as the slave takes.
      do_xfer(32'h0000_0700, 32'h0, 1'b0, 4'hF, 32'h9999_AAAA, 20, K_ACK, 0);
      max_d = 5;
`endif

      // Request while flushing in IDLE is not launched.
      cpu_ce_i = 1'b1; flush_i = 1'b1; cpu_addr_i = 32'h800;
      @(negedge clk);
      chk("idle_flush_stallreq", 32'(stallreq), 32'd0);
      step();
      cpu_ce_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      chk("idle_flush_cyc", 32'(bus.wishbone_cyc_o), 32'd0);
      step();

      // Reset in the middle of BUSY while an ack is being presented.
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h900; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
      cpu_data_i = 32'h0;
      @(negedge clk);
      step();
      cpu_ce_i = 1'b0;
      @(negedge clk);
      chk("pre_rst_cyc", 32'(bus.wishbone_cyc_o), 32'd1);
      step();
      #1;
      rst = 1'b1;
      bus.wishbone_ack_i = 1'b1;
      bus.wishbone_data_i = 32'hA5A5_5A5A;
      #1;
      chk("midrst_stallreq", 32'(stallreq), 32'd0);
      chk("midrst_data", cpu_data_o, 32'd0);
      chk("midrst_err", 32'(cpu_err_o), 32'd0);
      chk("midrst_cyc", 32'(bus.wishbone_cyc_o), 32'd0);
      chk("midrst_addr", bus.wishbone_addr_o, 32'd0);
      step();
      rst = 1'b0;
      bus.wishbone_ack_i = 1'b0;
      @(negedge clk);
      chk("postrst_cyc", 32'(bus.wishbone_cyc_o), 32'd0);
      step();
      do_xfer(32'h0000_0A00, 32'h0, 1'b0, 4'hF, 32'h1357_9BDF, 2, K_ACK, 0);

      // Randomized traffic.
      for (int n = 0; n < 60; n++) begin
`ifdef WB_TIMEOUT_EN
         k = kind_t'($urandom_range(0, 4));
`else
         k = kind_t'($urandom_range(0, 3));
`endif
         do_xfer($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom),
                 $urandom, (k == K_TIMEOUT) ? TB_TIMEOUT - 1 : $urandom_range(0, max_d),
                 k, $urandom_range(0, 3));
      end

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
